// File: rtl/key_debounce_multi_pkg.sv
// Shared constants for the multi-key debouncer.
// Channel FSM encodings and default 50 MHz timing values.
package key_debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kd_state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 10 ms stable time, 1 s long-press time.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;
  localparam int unsigned DEF_CNT_WIDTH       = 32;
  localparam int unsigned DEF_EVT_WIDTH       = 8;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF sync, debounce FSM, timer, press counter.
// Ports: clk, rst, key_in, cnt_clr -> key_level/press/release/long, press_cnt.
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int unsigned EVT_WIDTH       = DEF_EVT_WIDTH,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_in,
  input  logic                 cnt_clr,
  output logic                 key_level,
  output logic                 key_press,
  output logic                 key_release,
  output logic                 key_long,
  output logic [EVT_WIDTH-1:0] press_cnt
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_MAX =
    CNT_WIDTH'(LONG_CYCLES);
  // Timer value one step before LONG_CYCLES-1.
  localparam logic [CNT_WIDTH-1:0] LONG_PRE =
    CNT_WIDTH'(LONG_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  kd_state_e            state;
  logic [CNT_WIDTH-1:0] timer;
  logic [CNT_WIDTH-1:0] timer_sat;
  logic                 press_hit;

  always_comb begin
    timer_sat = (timer == LONG_MAX) ? LONG_MAX : timer + ONE;
    press_hit = (state == ST_PRESS_WAIT) && s2 &&
                (timer == DB_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= ST_IDLE;
      timer       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      press_cnt   <= '0;
    end else begin
      s1          <= key_in ^ ACTIVE_LOW;
      s2          <= s1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_PRESS_WAIT;
            timer <= ONE;
          end else begin
            timer <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state     <= ST_PRESSED;
            key_level <= 1'b1;
            key_press <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end
        ST_PRESSED: begin
          if (!s2) begin
            state <= ST_RELEASE_WAIT;
            timer <= ONE;
          end else begin
            timer    <= timer_sat;
            key_long <= (timer == LONG_PRE);
          end
        end
        ST_RELEASE_WAIT: begin
          if (s2) begin
            // Bounce inside a press: park timer so long cannot refire.
            state <= ST_PRESSED;
            timer <= LONG_MAX;
          end else if (timer == DB_LAST) begin
            state       <= ST_IDLE;
            key_level   <= 1'b0;
            key_release <= 1'b1;
            timer       <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase

      // A clear coinciding with a press keeps that press.
      if (cnt_clr) begin
        press_cnt <= press_hit ? EVT_WIDTH'(1) : '0;
      end else if (press_hit) begin
        press_cnt <= press_cnt + EVT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: NUM_KEYS independent channels.
// Ports: clk, rst, key_in, cnt_clr -> level/press/release/long, press_cnt.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int unsigned EVT_WIDTH       = DEF_EVT_WIDTH,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_in,
  input  logic [NUM_KEYS-1:0]           cnt_clr,
  output logic [NUM_KEYS-1:0]           key_level,
  output logic [NUM_KEYS-1:0]           key_press,
  output logic [NUM_KEYS-1:0]           key_release,
  output logic [NUM_KEYS-1:0]           key_long,
  output logic [NUM_KEYS*EVT_WIDTH-1:0] press_cnt
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .EVT_WIDTH       (EVT_WIDTH),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .cnt_clr     (cnt_clr[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .press_cnt   (press_cnt[i*EVT_WIDTH +: EVT_WIDTH])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi.
// Two instances: active-high and active-low key polarity.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] cnt_clr;
  logic [3:0] lvl, prs, rel, lng;
  logic [7:0] pc;
  logic [3:0] key_in_b;
  logic [3:0] cnt_clr_b;
  logic [3:0] lvl_b, prs_b, rel_b, lng_b;
  logic [7:0] pc_b;

  int checks = 0;
  int errors = 0;
  int np [4];
  int nr [4];
  int nl [4];
  int npb = 0;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32),
    .CNT_WIDTH(8), .EVT_WIDTH(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .cnt_clr(cnt_clr),
    .key_level(lvl), .key_press(prs), .key_release(rel),
    .key_long(lng), .press_cnt(pc)
  );

  key_debounce_multi #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32),
    .CNT_WIDTH(8), .EVT_WIDTH(2), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in_b), .cnt_clr(cnt_clr_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .key_long(lng_b), .press_cnt(pc_b)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      np[i] <= np[i] + int'(prs[i]);
      nr[i] <= nr[i] + int'(rel[i]);
      nl[i] <= nl[i] + int'(lng[i]);
    end
    npb <= npb + int'(prs_b != 4'd0) + int'(rel_b != 4'd0)
               + int'(lng_b != 4'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bp, br, bl;
    rst       = 1'b1;
    key_in    = 4'b0000;
    cnt_clr   = 4'b0000;
    key_in_b  = 4'b1111;
    cnt_clr_b = 4'b0000;
    step(2);
    chk("rst_lvl", 32'(lvl), 32'h0);
    chk("rst_evt", 32'({prs, rel, lng}), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_b", 32'({lvl_b, prs_b, pc_b}), 32'h0);
    rst = 1'b0;

    // 1: key0 rises at edge 10, falls at edge 30
    step(9);
    key_in[0] = 1'b1;
    step(9);
    chk("s1_pre_prs", 32'(prs), 32'h0);
    chk("s1_pre_lvl", 32'(lvl), 32'h0);
    step(1);
    chk("s1_prs", 32'(prs), 32'h1);
    chk("s1_lvl", 32'(lvl), 32'h1);
    chk("s1_pc", 32'(pc), 32'h01);
    step(1);
    chk("s1_prs_1cyc", 32'(prs), 32'h0);
    chk("s1_lvl_hold", 32'(lvl), 32'h1);
    step(9);
    key_in[0] = 1'b0;
    step(9);
    chk("s1_pre_rel", 32'(rel), 32'h0);
    chk("s1_lvl_rw", 32'(lvl), 32'h1);
    step(1);
    chk("s1_rel", 32'(rel), 32'h1);
    chk("s1_lvl_off", 32'(lvl), 32'h0);
    step(1);
    chk("s1_rel_1cyc", 32'(rel), 32'h0);

    // 2a: 5-cycle glitch on key1
    bp = np[1];
    key_in[1] = 1'b1;
    step(5);
    key_in[1] = 1'b0;
    step(15);
    chk("s2_glitch_lvl", 32'(lvl[1]), 32'h0);
    chk("s2_glitch_prs", 32'(np[1] - bp), 32'h0);
    chk("s2_glitch_pc", 32'(pc[3:2]), 32'h0);

    // 2b: press then bouncy release on key1
    bp = np[1];
    br = nr[1];
    key_in[1] = 1'b1;
    step(12);
    chk("s2_lvl_on", 32'(lvl[1]), 32'h1);
    key_in[1] = 1'b0;
    step(3);
    key_in[1] = 1'b1;
    step(3);
    key_in[1] = 1'b0;
    step(3);
    key_in[1] = 1'b1;
    step(3);
    key_in[1] = 1'b0;
    step(20);
    chk("s2_one_rel", 32'(nr[1] - br), 32'h1);
    chk("s2_one_prs", 32'(np[1] - bp), 32'h1);
    chk("s2_lvl_off", 32'(lvl[1]), 32'h0);
    chk("s2_pc", 32'(pc[3:2]), 32'h1);

    // 3: long press on key2 with dropout afterwards
    br = nr[2];
    bl = nl[2];
    key_in[2] = 1'b1;
    step(9);
    chk("s3_pre_prs", 32'(prs[2]), 32'h0);
    step(1);
    chk("s3_prs", 32'(prs), 32'h4);
    step(30);
    chk("s3_pre_long", 32'(lng[2]), 32'h0);
    step(1);
    chk("s3_long", 32'(lng), 32'h4);
    chk("s3_long_noprs", 32'(prs), 32'h0);
    step(1);
    chk("s3_long_1cyc", 32'(lng), 32'h0);
    key_in[2] = 1'b0;
    step(2);
    key_in[2] = 1'b1;
    step(25);
    chk("s3_one_long", 32'(nl[2] - bl), 32'h1);
    chk("s3_no_rel", 32'(nr[2] - br), 32'h0);
    chk("s3_lvl_held", 32'(lvl[2]), 32'h1);
    key_in[2] = 1'b0;
    step(12);
    chk("s3_rel", 32'(nr[2] - br), 32'h1);
    chk("s3_lvl_off", 32'(lvl[2]), 32'h0);
    chk("s3_long_total", 32'(nl[2] - bl), 32'h1);

    // 4: five presses on key3, counter wraps
    for (int i = 0; i < 5; i++) begin
      key_in[3] = 1'b1;
      step(10);
      chk("s4_prs", 32'(prs[3]), 32'h1);
      chk("s4_pc", 32'(pc[7:6]), 32'((i + 1) % 4));
      step(3);
      key_in[3] = 1'b0;
      step(12);
    end
    key_in[3] = 1'b1;
    step(9);
    cnt_clr[3] = 1'b1;
    step(1);
    chk("s4_clr_prs", 32'(prs[3]), 32'h1);
    chk("s4_clr_pc", 32'(pc[7:6]), 32'h1);
    cnt_clr[3] = 1'b0;
    step(1);
    chk("s4_pc_hold", 32'(pc[7:6]), 32'h1);
    cnt_clr[3] = 1'b1;
    step(1);
    chk("s4_clr_only", 32'(pc[7:6]), 32'h0);
    cnt_clr[3] = 1'b0;
    key_in[3] = 1'b0;
    step(12);

    // 5: reset during key0 debounce (timer=5)
    key_in[0] = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    chk("s5_rst_prs", 32'(prs), 32'h0);
    chk("s5_rst_lvl", 32'(lvl), 32'h0);
    chk("s5_rst_pc", 32'(pc), 32'h0);
    rst = 1'b0;
    step(9);
    chk("s5_pre_prs", 32'(prs), 32'h0);
    step(1);
    chk("s5_prs", 32'(prs), 32'h1);
    chk("s5_pc", 32'(pc), 32'h01);
    key_in[0] = 1'b0;
    step(12);

    // 6: active-low instance
    chk("s6_idle_evt", 32'(npb), 32'h0);
    chk("s6_idle_lvl", 32'(lvl_b), 32'h0);
    key_in_b[0] = 1'b0;
    step(9);
    chk("s6_pre_prs", 32'(prs_b), 32'h0);
    step(1);
    chk("s6_prs", 32'(prs_b), 32'h1);
    chk("s6_lvl", 32'(lvl_b), 32'h1);
    chk("s6_pc", 32'(pc_b), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
